// File: rtl/div_arbiter.sv
// Arbitrates two request channels onto one shared combinational divider; round-robin on ties.
// Latency: done pulses in the cycle after edge E+SETTLE+1, where E is the grant edge.
// Backpressure: requests are held high until done and are sampled only in IDLE.
// Build option: DIV_ARBITER_ZERO_BYPASS_EN skips the divider for a zero divisor.
module div_arbiter #(
  parameter int M      = 9,
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [M:0]   did0,
  input  logic [N:0]   div0,
  input  logic         req1,
  input  logic [M:0]   did1,
  input  logic [N:0]   div1,
  output logic         done0,
  output logic         done1,
  output logic [M:0]   res_quo,
  output logic [M:0]   res_rem,
  output logic         res_err,
  output logic         busy,
  output logic [M:0]   dv_did,
  output logic [N:0]   dv_div,
  input  logic [M:0]   dv_quo,
  input  logic [M:0]   dv_rem,
  input  logic         dv_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_RSVD = 2'd3;

  // Final count value of the settle window (counter starts at 0 on grant).
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last;     // channel served most recently
  logic       gnt;      // channel owning the current operation
  logic       pick;     // channel that would be granted this cycle
  logic [M:0] pick_did;
  logic [N:0] pick_div;
  logic       bypass;

  // On a tie the channel not served last wins; a lone requester always wins.
  always_comb begin
    pick     = (req0 && req1) ? ~last : req1;
    pick_did = pick ? did1 : did0;
    pick_div = pick ? div1 : div0;
  end

`ifdef DIV_ARBITER_ZERO_BYPASS_EN
  assign bypass = (pick_div == '0);
`else
  assign bypass = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // Arbitration FSM, settle counter, divider operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      gnt     <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res_quo <= '0;
      res_rem <= '0;
      res_err <= 1'b0;
      dv_did  <= '0;
      dv_div  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt  <= pick;
            last <= pick;
            cnt  <= '0;
            if (bypass) begin
              // Zero divisor answered locally; divider operands keep their old value.
              res_quo <= '0;
              res_rem <= '0;
              res_err <= 1'b1;
              state   <= S_DONE;
            end else begin
              dv_did <= pick_did;
              dv_div <= pick_div;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            res_quo <= dv_quo;
            res_rem <= dv_rem;
            res_err <= dv_err;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          done0 <= ~gnt;
          done1 <= gnt;
          state <= S_IDLE;
        end
        S_RSVD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: table of single-channel operations plus
// hand-written sequences for ties, back-to-back grants and reset mid-operation.
// A behavioural divider stub drives the dv_* inputs.
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, req1;
  logic [9:0] did0, did1;
  logic [4:0] div0, div1;
  logic       done0, done1, res_err, busy, dv_err;
  logic [9:0] res_quo, res_rem, dv_did, dv_quo, dv_rem;
  logic [4:0] dv_div;

  // second instance with a longer settle window
  logic       rst3, req3;
  logic       done0_3, done1_3, res_err_3, busy_3, dv_err_3;
  logic [9:0] res_quo_3, res_rem_3, dv_did_3, dv_quo_3, dv_rem_3;
  logic [4:0] dv_div_3;

  always #5 clk = ~clk;

  // Divider stub: zero dividend reports the divisor as remainder; zero divisor flags error.
  function automatic logic [9:0] fquo(input logic [9:0] a, input logic [4:0] b);
    if (b == 5'd0) return 10'h3FF;
    if (a == 10'd0) return 10'd0;
    return a / {5'd0, b};
  endfunction
  function automatic logic [9:0] frem(input logic [9:0] a, input logic [4:0] b);
    if (b == 5'd0) return a;
    if (a == 10'd0) return {5'd0, b};
    return a % {5'd0, b};
  endfunction

  assign dv_quo   = fquo(dv_did, dv_div);
  assign dv_rem   = frem(dv_did, dv_div);
  assign dv_err   = (dv_div == 5'd0);
  assign dv_quo_3 = fquo(dv_did_3, dv_div_3);
  assign dv_rem_3 = frem(dv_did_3, dv_div_3);
  assign dv_err_3 = (dv_div_3 == 5'd0);

  div_arbiter #(.M(9), .N(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .did0(did0), .div0(div0),
    .req1(req1), .did1(did1), .div1(div1),
    .done0(done0), .done1(done1),
    .res_quo(res_quo), .res_rem(res_rem), .res_err(res_err), .busy(busy),
    .dv_did(dv_did), .dv_div(dv_div),
    .dv_quo(dv_quo), .dv_rem(dv_rem), .dv_err(dv_err)
  );

  div_arbiter #(.M(9), .N(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req0(req3), .did0(did0), .div0(div0),
    .req1(1'b0), .did1(did1), .div1(div1),
    .done0(done0_3), .done1(done1_3),
    .res_quo(res_quo_3), .res_rem(res_rem_3), .res_err(res_err_3), .busy(busy_3),
    .dv_did(dv_did_3), .dv_div(dv_div_3),
    .dv_quo(dv_quo_3), .dv_rem(dv_rem_3), .dv_err(dv_err_3)
  );

  typedef struct {
    logic       r0;
    logic       r1;
    logic [9:0] d0;
    logic [4:0] v0;
    logic [9:0] d1;
    logic [4:0] v1;
    int         ch;
    int         lat;
    logic [9:0] quo;
    logic [9:0] rem;
    logic       err;
    logic [4:0] dvdiv;
  } vec_t;

`ifdef DIV_ARBITER_ZERO_BYPASS_EN
  localparam int         Z_LAT   = 1;
  localparam logic [9:0] Z_QUO   = 10'd0;
  localparam logic [9:0] Z_REM   = 10'd0;
  localparam logic [4:0] Z_DVDIV = 5'd9;   // left over from the previous vector
`else
  localparam int         Z_LAT   = 2;
  localparam logic [9:0] Z_QUO   = 10'h3FF;
  localparam logic [9:0] Z_REM   = 10'd77;
  localparam logic [4:0] Z_DVDIV = 5'd0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Called right after the sampling edge; returns cycles until a done pulse and its channel.
  task automatic wait_done(output int k, output int ch);
    k  = 0;
    ch = -1;
    while (k < 20 && ch < 0) begin
      @(posedge clk); #1;
      k++;
      if (done0 && done1) ch = 2;
      else if (done0)     ch = 0;
      else if (done1)     ch = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
  endtask

  vec_t vt[6];
  int   k, ch;
  logic seen;

  initial begin
    vt[0] = '{1'b1, 1'b0, 10'd100, 5'd7,  10'd0,    5'd0,  0, 2,     10'd14,   10'd2, 1'b0, 5'd7};
    vt[1] = '{1'b0, 1'b1, 10'd0,   5'd0,  10'd0,    5'd5,  1, 2,     10'd0,    10'd5, 1'b0, 5'd5};
    vt[2] = '{1'b0, 1'b1, 10'd0,   5'd0,  10'd1023, 5'd31, 1, 2,     10'd33,   10'd0, 1'b0, 5'd31};
    vt[3] = '{1'b1, 1'b0, 10'd5,   5'd9,  10'd0,    5'd0,  0, 2,     10'd0,    10'd5, 1'b0, 5'd9};
    vt[4] = '{1'b1, 1'b0, 10'd77,  5'd0,  10'd0,    5'd0,  0, Z_LAT, Z_QUO,    Z_REM, 1'b1, Z_DVDIV};
    vt[5] = '{1'b0, 1'b1, 10'd0,   5'd0,  10'd1000, 5'd1,  1, 2,     10'd1000, 10'd0, 1'b0, 5'd1};

    req0 = 0; req1 = 0; req3 = 0;
    did0 = '0; div0 = '0; did1 = '0; div1 = '0;
    do_reset();

    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_busy",  busy, 0);
    check("rst_quo",   res_quo, 0);
    check("rst_rem",   res_rem, 0);
    check("rst_err",   res_err, 0);
    check("rst_dvdid", dv_did, 0);
    check("rst_dvdiv", dv_div, 0);

    // single-channel operations
    for (int i = 0; i < 6; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1;
      did0 = vt[i].d0; div0 = vt[i].v0;
      did1 = vt[i].d1; div1 = vt[i].v1;
      @(posedge clk);
      wait_done(k, ch);
      req0 = 0; req1 = 0;
      check($sformatf("v%0d_chan", i),  ch, vt[i].ch);
      check($sformatf("v%0d_lat", i),   k, vt[i].lat);
      check($sformatf("v%0d_quo", i),   res_quo, vt[i].quo);
      check($sformatf("v%0d_rem", i),   res_rem, vt[i].rem);
      check($sformatf("v%0d_err", i),   res_err, vt[i].err);
      check($sformatf("v%0d_dvdiv", i), dv_div, vt[i].dvdiv);
      check($sformatf("v%0d_busy", i),  busy, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse", i), {done0, done1}, 0);
    end

    // simultaneous requests: channel 0 first after reset, and again on repeat
    do_reset();
    did0 = 10'd50; div0 = 5'd5; did1 = 10'd31; div1 = 5'd4;
    for (int r = 0; r < 2; r++) begin
      req0 = 1; req1 = 1;
      @(posedge clk);
      wait_done(k, ch);
      req0 = 0;
      check($sformatf("tie%0d_first", r), ch, 0);
      check($sformatf("tie%0d_lat0", r),  k, 2);
      check($sformatf("tie%0d_quo0", r),  res_quo, 10);
      check($sformatf("tie%0d_rem0", r),  res_rem, 0);
      wait_done(k, ch);
      req1 = 0;
      check($sformatf("tie%0d_second", r), ch, 1);
      check($sformatf("tie%0d_lat1", r),   k, 3);
      check($sformatf("tie%0d_quo1", r),   res_quo, 7);
      check($sformatf("tie%0d_rem1", r),   res_rem, 3);
      @(posedge clk); #1;
    end

    // after channel 0 is served alone, a tie goes to channel 1
    req0 = 1;
    @(posedge clk);
    wait_done(k, ch);
    req0 = 0;
    check("solo0_chan", ch, 0);
    @(posedge clk); #1;
    req0 = 1; req1 = 1;
    @(posedge clk);
    wait_done(k, ch);
    req1 = 0;
    check("rr_first", ch, 1);
    check("rr_quo1",  res_quo, 7);
    wait_done(k, ch);
    req0 = 0;
    check("rr_second", ch, 0);
    check("rr_quo0",   res_quo, 10);
    @(posedge clk); #1;

    // request held through done: immediate re-grant, busy low for one cycle
    did0 = 10'd100; div0 = 5'd7;
    req0 = 1;
    @(posedge clk);
    wait_done(k, ch);
    check("hold_chan1", ch, 0);
    check("hold_lat1",  k, 2);
    check("hold_busy_gap", busy, 0);
    @(posedge clk); #1;
    check("hold_busy_again", busy, 1);
    wait_done(k, ch);
    req0 = 0;
    check("hold_chan2", ch, 0);
    check("hold_lat2",  k, 2);
    check("hold_quo2",  res_quo, 14);
    check("hold_rem2",  res_rem, 2);
    check("hold_err2",  res_err, 0);
    @(posedge clk); #1;

    // SETTLE=3 instance: full operation, then reset on the second WAIT edge
    req3 = 1;
    @(posedge clk);
    k = 0; seen = 0;
    while (k < 20 && !seen) begin
      @(posedge clk); #1;
      k++;
      seen = done0_3;
    end
    req3 = 0;
    check("s3_lat", seen ? k : -1, 4);
    check("s3_quo", res_quo_3, 14);
    check("s3_rem", res_rem_3, 2);
    @(posedge clk); #1;
    req3 = 1;
    @(posedge clk); #1;   // grant edge
    req3 = 0;
    @(posedge clk); #1;   // first WAIT edge
    rst3 = 1;
    @(posedge clk); #1;   // second WAIT edge samples reset
    rst3 = 0;
    check("abort_busy",  busy_3, 0);
    check("abort_quo",   res_quo_3, 0);
    check("abort_rem",   res_rem_3, 0);
    check("abort_err",   res_err_3, 0);
    check("abort_dvdid", dv_did_3, 0);
    check("abort_dvdiv", dv_div_3, 0);
    check("abort_done",  {done0_3, done1_3}, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done0_3 || done1_3 || busy_3) seen = 1;
    end
    check("abort_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
